contador_sincrono_crescente: RTL

Synchronous up-counter, the ascending counterpart of the team's 6-bit synchronous down-counter. It counts 0 to MAX on each enabled clock edge, then either wraps to 0 or saturates at MAX, depending on a mode pin. It adds parallel load, a terminal-count flag, a registered wrap pulse and a saturating wrap-event counter. It is used as a timebase/event counter beside the down-counter in the counter/register exercise set.

---
 rtl/contador_sincrono_crescente.sv | 53 +++++
 1 files changed

// File: rtl/contador_sincrono_crescente.sv
// Synchronous up-counter 0..MAX with parallel load, wrap/saturate mode,
// a registered wrap pulse and a saturating count of wrap events.
module contador_sincrono_crescente #(
    parameter int WIDTH  = 6,
    parameter int MAX    = 63,
    parameter int RWIDTH = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              load,
    input  logic [WIDTH-1:0]  d,
    input  logic              sat_mode,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              wrap,
    output logic              sat,
    output logic [RWIDTH-1:0] wraps
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    logic at_max;

    assign at_max = (q == MAX_Q);
    assign tc     = at_max;
    assign sat    = sat_mode & at_max;

    // wrap defaults low every edge so it can only ever be a one-cycle pulse
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q     <= '0;
            wrap  <= 1'b0;
            wraps <= '0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                q <= (d > MAX_Q) ? MAX_Q : d;
            end else if (en) begin
                if (!at_max) begin
                    q <= q + WIDTH'(1);
                end else if (!sat_mode) begin
                    q    <= '0;
                    wrap <= 1'b1;
                    if (wraps != '1) begin
                        wraps <= wraps + RWIDTH'(1);
                    end
                end
            end
        end
    end

endmodule
